// File: rtl/tt_ctrl_seq.sv
// Design-select sequencer for the ctrl[2:0] pads: disable, reset selector, pulse inc N times, re-enable.
// Optional incremental selection (skip selector reset when moving upward) under TT_CTRL_SEQ_INCR_EN.
module tt_ctrl_seq #(
    parameter int PULSE_W = 4,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] sel_addr,
    input  logic              ena_req,
    output logic              ctrl_ena,
    output logic              ctrl_sel_inc,
    output logic              ctrl_sel_rst_n,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIS   = 3'd1,
        RST   = 3'd2,
        REC   = 3'd3,
        INC_H = 3'd4,
        INC_L = 3'd5,
        ENA   = 3'd6
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(PULSE_W - 1);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] n_q;
    logic              skip_q;
    logic              ena_cap_q;
    logic              ctrl_ena_q, inc_q, sel_rst_n_q, busy_q, done_q;

    logic [ADDR_W-1:0] n_d;
    logic              skip_d;
    logic              phase_end;
    logic              pair_go;

`ifdef TT_CTRL_SEQ_INCR_EN
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] addr_cap_q;
    logic              cur_valid_q;

    // Moving upward from a known selection only needs the difference in pulses.
    always_comb begin
        skip_d = cur_valid_q && (sel_addr >= cur_addr_q);
        n_d    = skip_d ? (sel_addr - cur_addr_q) : sel_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr_q  <= '0;
            addr_cap_q  <= '0;
            cur_valid_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) addr_cap_q <= sel_addr;
            if (state_q == ENA) begin
                cur_addr_q  <= addr_cap_q;
                cur_valid_q <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        skip_d = 1'b0;
        n_d    = sel_addr;
    end
`endif

    assign phase_end = (cnt_q == PHASE_LAST);
    // REC, INC_L and a skipping DIS all hand over to the same "pulse again or finish" decision.
    assign pair_go   = phase_end && ((state_q == REC) || (state_q == INC_L) ||
                                     ((state_q == DIS) && skip_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            skip_q      <= 1'b0;
            ena_cap_q   <= 1'b0;
            ctrl_ena_q  <= 1'b0;
            inc_q       <= 1'b0;
            sel_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && state_q != ENA)
                cnt_q <= phase_end ? 8'd0 : cnt_q + 8'd1;

            unique case (state_q)
                IDLE: begin
                    sel_rst_n_q <= 1'b1;
                    if (start) begin
                        n_q        <= n_d;
                        skip_q     <= skip_d;
                        ena_cap_q  <= ena_req;
                        ctrl_ena_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= 8'd0;
                        state_q    <= DIS;
                    end
                end
                DIS: if (phase_end && !skip_q) begin
                    state_q     <= RST;
                    sel_rst_n_q <= 1'b0;
                end
                RST: if (phase_end) begin
                    state_q     <= REC;
                    sel_rst_n_q <= 1'b1;
                end
                INC_H: if (phase_end) begin
                    state_q <= INC_L;
                    inc_q   <= 1'b0;
                end
                ENA:     state_q <= IDLE;
                default: ;
            endcase

            if (pair_go) begin
                if (n_q == '0) begin
                    state_q    <= ENA;
                    ctrl_ena_q <= ena_cap_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                end else begin
                    state_q <= INC_H;
                    inc_q   <= 1'b1;
                    n_q     <= n_q - 1'b1;
                end
            end
        end
    end

    assign ctrl_ena       = ctrl_ena_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Scoreboard bench for tt_ctrl_seq: sequence-level reference model, decoupled monitor on done.
module tb_tt_ctrl_seq;

    localparam int PW = 2;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] sel_addr = '0;
    logic          ena_req = 1'b0;
    logic          ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n, busy, done;
    logic [2:0]    state_dbg;

    tt_ctrl_seq #(.PULSE_W(PW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_addr(sel_addr), .ena_req(ena_req),
        .ctrl_ena(ctrl_ena), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // scoreboard
    typedef struct packed {
        logic [15:0] cycles;
        logic [15:0] pulses;
        logic [15:0] rst_low;
        logic        ena;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   exp_seqs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // reference model: selection is a count of pulses from the current position
    int m_cur   = 0;
    bit m_valid = 0;

    function automatic exp_t model_seq(input int addr, input logic ena);
        exp_t e;
        bit   full;
        int   n;
`ifdef TT_CTRL_SEQ_INCR_EN
        full = !(m_valid && addr >= m_cur);
        n    = full ? addr : addr - m_cur;
`else
        full = 1;
        n    = addr;
`endif
        m_cur     = addr;
        m_valid   = 1;
        e.cycles  = 16'(((full ? 3 : 1) + 2 * n) * PW + 1);
        e.pulses  = 16'(n);
        e.rst_low = 16'(full ? PW : 0);
        e.ena     = ena;
        return e;
    endfunction

    // monitor
    int busy_cnt = 0, inc_cyc = 0, inc_edges = 0, rst_low = 0;
    bit prev_inc = 0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0; inc_cyc = 0; inc_edges = 0; rst_low = 0; prev_inc = 0;
        end else begin
            chk("inc_with_sel_rst", {31'd0, ctrl_sel_inc & ~ctrl_sel_rst_n}, 0);
            if (ctrl_sel_inc || !ctrl_sel_rst_n) chk("ena_low_while_ctrl_active", {31'd0, ctrl_ena}, 0);
            if (busy) begin
                busy_cnt++;
                chk("ena_low_while_busy", {31'd0, ctrl_ena}, 0);
                if (ctrl_sel_inc) inc_cyc++;
                if (ctrl_sel_inc && !prev_inc) inc_edges++;
                if (!ctrl_sel_rst_n) rst_low++;
            end
            prev_inc = ctrl_sel_inc;
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", {31'd0, busy}, 0);
                chk("done_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("seq_cycles", busy_cnt + 1, {16'd0, e.cycles});
                    chk("inc_pulses", inc_edges, {16'd0, e.pulses});
                    chk("inc_high_cycles", inc_cyc, {16'd0, e.pulses} * PW);
                    chk("sel_rst_low_cycles", rst_low, {16'd0, e.rst_low});
                    chk("final_ctrl_ena", {31'd0, ctrl_ena}, {31'd0, e.ena});
                end
                busy_cnt = 0; inc_cyc = 0; inc_edges = 0; rst_low = 0;
            end
        end
    end

    // driver tasks (called positioned at a negedge)
    task automatic run_seq(input int addr, input logic ena, input bit hold, input bit noisy);
        bit seen;
        exp_q.push_back(model_seq(addr, ena));
        exp_seqs++;
        start    = 1'b1;
        sel_addr = AW'(addr);
        ena_req  = ena;
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("sel_rst_n_high_after_start", {31'd0, ctrl_sel_rst_n}, 1);
        start = hold;
        seen  = 0;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (noisy) begin
                start    = hold ? 1'b1 : 1'($urandom_range(0, 1));
                sel_addr = AW'($urandom);
                ena_req  = 1'($urandom);
            end
            @(negedge clk);
        end
        chk("done_within_bound", {31'd0, seen}, 1);
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic abort_test();
        bit seen;
        void'(model_seq(5, 1'b1));
        exp_q.push_back(model_seq(5, 1'b1));
        start    = 1'b1;
        sel_addr = AW'(5);
        ena_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 200; k++) begin
            if (ctrl_sel_inc) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_inc_h", {31'd0, seen}, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_ctrl_ena", {31'd0, ctrl_ena}, 0);
        chk("abort_inc", {31'd0, ctrl_sel_inc}, 0);
        chk("abort_sel_rst_n", {31'd0, ctrl_sel_rst_n}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        void'(exp_q.pop_back());
        m_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_seq(2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ctrl_ena", {31'd0, ctrl_ena}, 0);
        chk("reset_inc", {31'd0, ctrl_sel_inc}, 0);
        chk("reset_sel_rst_n", {31'd0, ctrl_sel_rst_n}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("sel_rst_n_after_release", {31'd0, ctrl_sel_rst_n}, 1);
        chk("idle_not_busy", {31'd0, busy}, 0);

        run_seq(3, 1'b1, 1'b0, 1'b0);
        run_seq(5, 1'b1, 1'b0, 1'b0);
        run_seq(1, 1'b0, 1'b0, 1'b0);
        run_seq(0, 1'b0, 1'b0, 1'b0);
        run_seq(15, 1'b1, 1'b0, 1'b0);
        run_seq(15, 1'b0, 1'b1, 1'b1);
        abort_test();
        for (int i = 0; i < 24; i++)
            run_seq(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));

        repeat (5) @(negedge clk);
        chk("total_done_pulses", done_cnt, exp_seqs);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
